// File: rtl/awgn_pkg.sv
// Shared constants and helpers for the AWGN channel generator: LFSR polynomial,
// lane seeding and signed saturation.
package awgn_pkg;

    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'h1ACE_B00C;
    localparam logic [31:0] SEED_STRIDE  = 32'h9E37_79B9;

    // Galois right-shift step: feedback from bit 0.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // An all-zero state would lock the LFSR, so it is replaced by 1.
    function automatic logic [31:0] lane_seed(input logic [31:0] s, input int unsigned k);
        logic [31:0] m;
        m = s ^ (32'(k) * SEED_STRIDE);
        return (m == 32'h0) ? 32'h1 : m;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/awgn_lfsr.sv
// One uniform noise lane: 32-bit Galois LFSR that is reseeded on load and
// steps only when the top accepts a sample.
module awgn_lfsr
    import awgn_pkg::*;
#(
    parameter int          U_W  = 12,
    parameter int unsigned LANE = 0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [31:0]    seed_i,
    input  logic           load_i,
    input  logic           step_i,
    output logic [31:0]    state_o,
    output logic [U_W-1:0] uniform_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = lane_seed(seed_i, LANE);
        end else if (step_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= lane_seed(DEFAULT_SEED, LANE);
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o   = state_q;
    assign uniform_o = state_q[U_W-1:0];

endmodule

// File: rtl/awgn_channel_gen.sv
// AWGN channel: CLT sum of LFSR uniforms scaled by a runtime sigma, added to the
// input sample with saturation. Three-stage pipeline (sum, multiply, add).
module awgn_channel_gen
    import awgn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 13,
    parameter int U_W    = 12,
    parameter int N_SUM  = 4,
    parameter int SHIFT  = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              seed_i,
    input  logic                     seed_load_i,
    input  logic                     noise_en_i,
    input  logic [DATA_W-1:0]        sigma_q_i,
    input  logic signed [DATA_W-1:0] in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic signed [DATA_W-1:0] out_data_o,
    output logic signed [DATA_W-1:0] out_noise_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i
);

    localparam int G_W = U_W + $clog2(N_SUM);
    localparam int P_W = G_W + DATA_W + 1;

    if (FRAC_W >= DATA_W || N_SUM < 1 || N_SUM > 8) begin : g_param_check
        $error("awgn_channel_gen: unsupported FRAC_W/N_SUM");
    end

    logic adv;
    logic accept;

    logic [N_SUM-1:0][31:0]  lane_state;
    logic [N_SUM-1:0][U_W-1:0] lane_uni;
    logic                    state_unused;

    logic                     s1_valid_q, s1_valid_d;
    logic signed [G_W-1:0]    s1_g_q, s1_g_d;
    logic signed [DATA_W-1:0] s1_data_q, s1_data_d;
    logic                     s1_en_q, s1_en_d;
    logic [DATA_W-1:0]        s1_sigma_q, s1_sigma_d;

    logic                     s2_valid_q, s2_valid_d;
    logic signed [DATA_W-1:0] s2_data_q, s2_data_d;
    logic signed [DATA_W-1:0] s2_n_q, s2_n_d;

    logic                     s3_valid_q, s3_valid_d;
    logic signed [DATA_W-1:0] s3_data_q, s3_data_d;
    logic signed [DATA_W-1:0] s3_n_q, s3_n_d;

    logic signed [G_W-1:0]    g_sum;
    logic signed [P_W-1:0]    prod;
    logic signed [P_W-1:0]    prod_sh;
    logic signed [DATA_W-1:0] noise_n;
    logic signed [DATA_W:0]   add_full;
    logic signed [DATA_W-1:0] add_sat;

    // The whole pipeline moves as one; a pending output blocks everything.
    assign adv        = !s3_valid_q || out_ready_i;
    assign in_ready_o = adv && !seed_load_i;
    assign accept     = in_valid_i && in_ready_o;

    for (genvar k = 0; k < N_SUM; k++) begin : g_lane
        awgn_lfsr #(.U_W(U_W), .LANE(k)) u_lfsr (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .seed_i    (seed_i),
            .load_i    (seed_load_i),
            .step_i    (accept),
            .state_o   (lane_state[k]),
            .uniform_o (lane_uni[k])
        );
    end

    assign state_unused = ^lane_state;

    always_comb begin
        g_sum = '0;
        for (int k = 0; k < N_SUM; k++) begin
            g_sum = g_sum + G_W'($signed(lane_uni[k]));
        end
    end

    always_comb begin
        prod     = P_W'(s1_g_q) * P_W'($signed({1'b0, s1_sigma_q}));
        prod_sh  = prod >>> SHIFT;
        noise_n  = s1_en_q ? DATA_W'(sat(64'(prod_sh), DATA_W)) : '0;
        add_full = (DATA_W+1)'(s2_data_q) + (DATA_W+1)'(s2_n_q);
        add_sat  = DATA_W'(sat(64'(add_full), DATA_W));
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_g_d     = s1_g_q;
        s1_data_d  = s1_data_q;
        s1_en_d    = s1_en_q;
        s1_sigma_d = s1_sigma_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_n_d     = s2_n_q;
        s3_valid_d = s3_valid_q;
        s3_data_d  = s3_data_q;
        s3_n_d     = s3_n_q;
        if (seed_load_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s3_valid_d = 1'b0;
        end else if (adv) begin
            s1_valid_d = accept;
            s2_valid_d = s1_valid_q;
            s3_valid_d = s2_valid_q;
            if (accept) begin
                s1_g_d     = g_sum;
                s1_data_d  = in_data_i;
                s1_en_d    = noise_en_i;
                s1_sigma_d = sigma_q_i;
            end
            if (s1_valid_q) begin
                s2_data_d = s1_data_q;
                s2_n_d    = noise_n;
            end
            if (s2_valid_q) begin
                s3_data_d = add_sat;
                s3_n_d    = s2_n_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_g_q     <= '0;
            s1_data_q  <= '0;
            s1_en_q    <= 1'b0;
            s1_sigma_q <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_n_q     <= '0;
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
            s3_n_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_g_q     <= s1_g_d;
            s1_data_q  <= s1_data_d;
            s1_en_q    <= s1_en_d;
            s1_sigma_q <= s1_sigma_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_n_q     <= s2_n_d;
            s3_valid_q <= s3_valid_d;
            s3_data_q  <= s3_data_d;
            s3_n_q     <= s3_n_d;
        end
    end

    assign out_valid_o = s3_valid_q;
    assign out_data_o  = s3_data_q;
    assign out_noise_o = s3_n_q;

endmodule
